// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the keypad program loader: FSM states,
// digit-count sizing and keypad one-hot decoding.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    function automatic int ndig_of(input int word_w);
        return word_w / 4;
    endfunction

    function automatic int dcnt_w(input int word_w);
        return $clog2(word_w / 4 + 1);
    endfunction

    function automatic logic is_onehot(input logic [15:0] k);
        return (k != 16'h0) && ((k & (k - 16'h1)) == 16'h0);
    endfunction

    // Key i carries hex digit i-1, so key 0 wraps around to 0xF.
    function automatic logic [3:0] key_to_nibble(input logic [15:0] k);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) idx = 4'(i);
        end
        return idx - 4'h1;
    endfunction

endpackage

// File: rtl/prog_loader_btn_debounce.sv
// Raw active-low button -> synchronised, debounced, one-cycle press pulse.
// Level must differ from the accepted level for DEB_CYCLES consecutive cycles.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clock,
    input  logic rst,
    input  logic btn_n,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= btn_n;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                cnt   <= '0;
                level <= s2;
                press <= ~s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Keypad program entry: assembles hex digits into words, writes them to
// sequential RAM addresses, then hands the RAM to the CPU on run.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int DEB_CYCLES = 500000
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic [15:0]                 keys,
    input  logic                        btn_store_n,
    input  logic                        btn_clear_n,
    input  logic                        btn_run_n,
    output logic                        ram_we,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [WORD_W-1:0]           ram_din,
    output logic [WORD_W-1:0]           disp_value,
    output logic [ADDR_W-1:0]           disp_addr,
    output logic [dcnt_w(WORD_W)-1:0]   digit_cnt,
    output logic                        full,
    output logic                        cpu_en
);
    localparam int NDIG = ndig_of(WORD_W);
    localparam int DCW  = dcnt_w(WORD_W);

    logic [15:0] key_s1, key_s2, key_prev;
    logic        nib_evt;
    logic [3:0]  nib;
    logic        store_evt, clear_evt, run_evt;

    state_t              state, state_n;
    logic [WORD_W-1:0]   entry_buf, entry_n;
    logic [ADDR_W-1:0]   addr_ptr, addr_n;
    logic [DCW-1:0]      cnt_n;
    logic                full_n;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_store (
        .clock(clock), .rst(rst), .btn_n(btn_store_n), .press(store_evt));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clock(clock), .rst(rst), .btn_n(btn_clear_n), .press(clear_evt));
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clock(clock), .rst(rst), .btn_n(btn_run_n), .press(run_evt));

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            key_s1   <= '0;
            key_s2   <= '0;
            key_prev <= '0;
        end else begin
            key_s1   <= keys;
            key_s2   <= key_s1;
            key_prev <= key_s2;
        end
    end

    // Only an idle->single-key transition counts; chords and their partial
    // releases never pass through all-zero, so they stay locked out.
    assign nib_evt = (key_prev == 16'h0) && is_onehot(key_s2);
    assign nib     = key_to_nibble(key_s2);

    always_comb begin
        state_n = state;
        entry_n = entry_buf;
        addr_n  = addr_ptr;
        cnt_n   = digit_cnt;
        full_n  = full;
        unique case (state)
            ST_ENTRY: begin
                if (run_evt) begin
                    state_n = ST_RUN;
                end else if (store_evt) begin
                    if (digit_cnt != '0) state_n = ST_WRITE;
                end else if (clear_evt) begin
                    if (digit_cnt != '0) begin
                        entry_n = '0;
                        cnt_n   = '0;
                    end else begin
                        addr_n = '0;
                    end
                end else if (nib_evt) begin
                    entry_n = {entry_buf[WORD_W-5:0], nib};
                    cnt_n   = (digit_cnt == DCW'(NDIG)) ? digit_cnt : digit_cnt + DCW'(1);
                end
            end
            ST_WRITE: begin
                entry_n = '0;
                cnt_n   = '0;
                if (addr_ptr == '1) begin
                    full_n  = 1'b1;
                    state_n = ST_FULL;
                end else begin
                    addr_n  = addr_ptr + ADDR_W'(1);
                    state_n = ST_ENTRY;
                end
            end
            ST_FULL: begin
                if (run_evt) begin
                    state_n = ST_RUN;
                end else if (store_evt) begin
                    state_n = ST_FULL;
                end else if (clear_evt) begin
                    addr_n  = '0;
                    full_n  = 1'b0;
                    entry_n = '0;
                    cnt_n   = '0;
                    state_n = ST_ENTRY;
                end
            end
            ST_RUN: begin
                state_n = ST_RUN;
            end
            default: begin
                state_n = ST_ENTRY;
            end
        endcase
    end

    // ram_we and cpu_en are flops decoded from the next state so they are
    // glitch-free and line up exactly with the state they belong to.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= ST_ENTRY;
            entry_buf <= '0;
            addr_ptr  <= '0;
            digit_cnt <= '0;
            full      <= 1'b0;
            ram_we    <= 1'b0;
            cpu_en    <= 1'b0;
        end else begin
            state     <= state_n;
            entry_buf <= entry_n;
            addr_ptr  <= addr_n;
            digit_cnt <= cnt_n;
            full      <= full_n;
            ram_we    <= (state_n == ST_WRITE);
            cpu_en    <= (state_n == ST_RUN);
        end
    end

    assign ram_addr   = addr_ptr;
    assign ram_din    = entry_buf;
    assign disp_value = entry_buf;
    assign disp_addr  = addr_ptr;

endmodule
